// File: rtl/serial_rfa_sequencer.sv
// rtl/serial_rfa_sequencer.sv - bit-serial add/sub sequencer around one external reversible full adder
// Optional subtract mode: define SERIAL_SUB_EN.
module serial_rfa_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_SUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    output logic             fa_ctrl,
    input  logic             fa_s,
    input  logic             fa_cout
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
    logic             carry_reg;
    logic [CW-1:0]    bit_cnt;
    logic             sub_mode;
    logic             last_bit;
    logic             start;

`ifdef SERIAL_SUB_EN
    logic sub_reg;
    assign sub_mode = sub_reg;
`else
    assign sub_mode = 1'b0;
`endif

    assign last_bit  = (bit_cnt == CW'(WIDTH - 1));
    assign start     = (state == IDLE) && in_valid;
    assign sum       = sum_sr;
    assign carry_out = carry_reg;
    // Ctrl=1 would invert Cout inside the adder; plain addition needs it low.
    assign fa_ctrl   = 1'b0;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        fa_a      = 1'b0;
        fa_b      = 1'b0;
        fa_cin    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                busy   = 1'b1;
                fa_a   = a_sr[0];
                fa_b   = b_sr[0] ^ sub_mode;
                fa_cin = carry_reg;
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            sum_sr    <= '0;
            carry_reg <= 1'b0;
            bit_cnt   <= '0;
`ifdef SERIAL_SUB_EN
            sub_reg   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (start) begin
                a_sr    <= op_a;
                b_sr    <= op_b;
                bit_cnt <= '0;
`ifdef SERIAL_SUB_EN
                sub_reg   <= op_sub;
                carry_reg <= op_sub;
`else
                carry_reg <= 1'b0;
`endif
            end else if (state == RUN) begin
                // Result bits enter at the MSB so the LSB-first stream lands in place after WIDTH shifts.
                sum_sr    <= (sum_sr >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                carry_reg <= fa_cout;
                a_sr      <= a_sr >> 1;
                b_sr      <= b_sr >> 1;
                bit_cnt   <= bit_cnt + 1'b1;
            end
        end
    end

endmodule
